vga_timing_gen: RTL and testbench

Parametrised VGA timing generator with built-in test-pattern source, successor to the fixed 768x512 counter/sync pair. Porch, sync and active-region lengths, sync polarity and counter widths are set per instance. A pixel clock enable, a data-enable signal, pixel coordinates, and line/frame strobes drive downstream framebuffer readout. Sits between the board clock domain and the DAC/pin outputs at the top of the display path.

---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/vga_timing_gen_if.sv | 29 ++
 rtl/vga_axis_counter.sv | 45 ++++
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and pattern encodings for the VGA timing generator.
// Holds the 640x480@60 defaults, a 1024x768 preset and the axis-length helper.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_HS_POL   = 1'b0;
    localparam bit DEF_VS_POL   = 1'b0;
    localparam int DEF_XW       = 10;
    localparam int DEF_YW       = 10;

    localparam int XGA_H_ACTIVE = 1024;
    localparam int XGA_H_FP     = 24;
    localparam int XGA_H_SYNC   = 136;
    localparam int XGA_H_BP     = 160;
    localparam int XGA_V_ACTIVE = 768;
    localparam int XGA_V_FP     = 3;
    localparam int XGA_V_SYNC   = 6;
    localparam int XGA_V_BP     = 29;
    localparam bit XGA_HS_POL   = 1'b0;
    localparam bit XGA_VS_POL   = 1'b0;
    localparam int XGA_XW       = 11;
    localparam int XGA_YW       = 10;

    typedef enum logic [1:0] {
        PAT_BLACK  = 2'd0,
        PAT_BARS   = 2'd1,
        PAT_CHECK  = 2'd2,
        PAT_BORDER = 2'd3
    } pat_mode_e;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video-side bundle of the timing generator: enable/pattern select in, sync/coords/colour out.
// The master side is the generator; the slave side is whoever supplies pix_en and pat_mode.
interface vga_timing_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          pix_en;
    logic [1:0]    pat_mode;
    logic          h_sync;
    logic          v_sync;
    logic          de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic          R;
    logic          G;
    logic          B;

    modport master (
        input  pix_en, pat_mode,
        output h_sync, v_sync, de, x, y, line_start, frame_start, R, G, B
    );

    modport slave (
        output pix_en, pat_mode,
        input  h_sync, v_sync, de, x, y, line_start, frame_start, R, G, B
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One display axis: wrapping position counter plus its sync window and active flag.
// Region order along the axis is active, front porch, sync, back porch.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int W      = DEF_XW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         in_sync,
    output logic         active
);
    localparam int           TOTAL   = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);
    localparam logic [W-1:0] ACT_END = W'(ACTIVE);

    logic [W-1:0] count_r;

    // Position counter: advances on step, returns to 0 after the last position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else if (step) begin
            if (count_r == LAST) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + W'(1);
            end
        end
    end

    assign count   = count_r;
    assign wrap    = (count_r == LAST);
    assign in_sync = (count_r >= SYNC_LO) && (count_r < SYNC_HI);
    assign active  = (count_r < ACT_END);
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with built-in test patterns.
// Every output is registered from the counter state at the same pix_en edge, so all stay aligned.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = DEF_HS_POL,
    parameter bit VS_POL   = DEF_VS_POL,
    parameter int XW       = DEF_XW,
    parameter int YW       = DEF_YW
) (
    input logic              clk,
    input logic              rst,
    vga_timing_gen_if.master vif
);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    logic [XW-1:0] h_cnt_s;
    logic [YW-1:0] v_cnt_s;
    logic          h_wrap_s, v_wrap_unused_s;
    logic          h_win_s, v_win_s, h_act_s, v_act_s;
    logic          v_step_s;

    assign v_step_s = vif.pix_en & h_wrap_s;

    vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(XW)) u_h_axis (
        .clk(clk), .rst(rst), .step(vif.pix_en),
        .count(h_cnt_s), .wrap(h_wrap_s), .in_sync(h_win_s), .active(h_act_s)
    );

    vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(YW)) u_v_axis (
        .clk(clk), .rst(rst), .step(v_step_s),
        .count(v_cnt_s), .wrap(v_wrap_unused_s), .in_sync(v_win_s), .active(v_act_s)
    );

    pat_mode_e mode_r, mode_cur_s;
    logic      at_origin_s, de_s, edge_s, chk_s, cx_s, cy_s;
    logic [2:0] bar_s, pat_s, rgb_s;

    // Bit 4 of a coordinate is constant 0 when the axis is too narrow to reach it.
    if (XW > 4) begin : g_cx
        assign cx_s = h_cnt_s[4];
    end else begin : g_cx_narrow
        assign cx_s = 1'b0;
    end
    if (YW > 4) begin : g_cy
        assign cy_s = v_cnt_s[4];
    end else begin : g_cy_narrow
        assign cy_s = 1'b0;
    end

    // Pattern source for the pixel the counters point at; a new mode applies from pixel (0,0).
    always_comb begin
        at_origin_s = (h_cnt_s == '0) && (v_cnt_s == '0);
        if (at_origin_s) begin
            mode_cur_s = pat_mode_e'(vif.pat_mode);
        end else begin
            mode_cur_s = mode_r;
        end
        de_s   = h_act_s & v_act_s;
        bar_s  = 3'((32'(h_cnt_s) * 32'd8) / 32'(H_ACTIVE));
        chk_s  = cx_s ^ cy_s;
        edge_s = (h_cnt_s == '0) || (h_cnt_s == X_LAST) || (v_cnt_s == '0) || (v_cnt_s == Y_LAST);
        case (mode_cur_s)
            PAT_BLACK:  pat_s = 3'b000;
            PAT_BARS:   pat_s = bar_s;
            PAT_CHECK:  pat_s = {3{chk_s}};
            PAT_BORDER: pat_s = {3{edge_s}};
            default:    pat_s = 3'b000;
        endcase
        if (de_s) begin
            rgb_s = pat_s;
        end else begin
            rgb_s = 3'b000;
        end
    end

    logic          h_sync_r, v_sync_r, de_r, line_start_r, frame_start_r;
    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;
    logic [2:0]    rgb_r;

    // Output registers and mode latch; hold their value while pix_en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_r        <= PAT_BLACK;
            h_sync_r      <= ~HS_POL;
            v_sync_r      <= ~VS_POL;
            de_r          <= 1'b0;
            x_r           <= '0;
            y_r           <= '0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            rgb_r         <= 3'b000;
        end else if (vif.pix_en) begin
            mode_r        <= mode_cur_s;
            h_sync_r      <= h_win_s ? HS_POL : ~HS_POL;
            v_sync_r      <= v_win_s ? VS_POL : ~VS_POL;
            de_r          <= de_s;
            x_r           <= de_s ? h_cnt_s : '0;
            y_r           <= de_s ? v_cnt_s : '0;
            line_start_r  <= (h_cnt_s == '0);
            frame_start_r <= at_origin_s;
            rgb_r         <= rgb_s;
        end
    end

    assign vif.h_sync      = h_sync_r;
    assign vif.v_sync      = v_sync_r;
    assign vif.de          = de_r;
    assign vif.x           = x_r;
    assign vif.y           = y_r;
    assign vif.line_start  = line_start_r;
    assign vif.frame_start = frame_start_r;
    assign vif.R           = rgb_r[2];
    assign vif.G           = rgb_r[1];
    assign vif.B           = rgb_r[0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a 40x20 instance and the 4x3 small instance run side by side,
// checked cycle by cycle against a queued reference model plus a pixel table and period checks.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int A_HT = 56, A_VT = 28, B_HT = 8, B_VT = 6;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [7:0] x;
        logic [7:0] y;
        logic       ls;
        logic       fs;
        logic [2:0] rgb;
    } out_t;

    typedef struct {
        int         mode;
        int         px;
        int         py;
        logic [2:0] rgb;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       pix_en;
    logic [1:0] pat_mode;
    bit         pe_alt = 1'b0;
    int         n_cmp = 0;
    int         n_fail = 0;

    vga_timing_gen_if #(.XW(6), .YW(5)) ia ();
    vga_timing_gen_if #(.XW(3), .YW(3)) ib ();
    assign ia.pix_en   = pix_en;
    assign ia.pat_mode = pat_mode;
    assign ib.pix_en   = pix_en;
    assign ib.pat_mode = pat_mode;

    vga_timing_gen #(.H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
                     .V_ACTIVE(20), .V_FP(2), .V_SYNC(3), .V_BP(3),
                     .HS_POL(1'b0), .VS_POL(1'b0), .XW(6), .YW(5))
        dut_a (.clk(clk), .rst(rst), .vif(ia));

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .HS_POL(1'b1), .VS_POL(1'b1), .XW(3), .YW(3))
        dut_b (.clk(clk), .rst(rst), .vif(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pix_en source: constant high, or toggling every clock when pe_alt is set
    initial begin
        pix_en = 1'b1;
        forever begin
            @(negedge clk);
            if (pe_alt) pix_en = ~pix_en;
            else        pix_en = 1'b1;
        end
    end

    function automatic out_t model(input int ha, input int hf, input int hsw, input int va,
                                   input int vf, input int vsw, input bit hp, input bit vp,
                                   input int h, input int v, input logic [1:0] m);
        out_t o;
        int hs0, vs0;
        hs0 = ha + hf;
        vs0 = va + vf;
        o.hs = (h >= hs0 && h < hs0 + hsw) ? hp : ~hp;
        o.vs = (v >= vs0 && v < vs0 + vsw) ? vp : ~vp;
        o.de = (h < ha) && (v < va);
        o.x  = o.de ? 8'(h) : 8'd0;
        o.y  = o.de ? 8'(v) : 8'd0;
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
        case (m)
            2'd1:    o.rgb = 3'((h * 8) / ha);
            2'd2:    o.rgb = {3{h[4] ^ v[4]}};
            2'd3:    o.rgb = {3{(h == 0) || (h == ha - 1) || (v == 0) || (v == va - 1)}};
            default: o.rgb = 3'b000;
        endcase
        if (!o.de) o.rgb = 3'b000;
        return o;
    endfunction

    function automatic out_t rst_val(input bit hp, input bit vp);
        out_t o;
        o = '0;
        o.hs = ~hp;
        o.vs = ~vp;
        return o;
    endfunction

    function automatic logic [1:0] nmode(input int h, input int v, input logic [1:0] m);
        return (h == 0 && v == 0) ? pat_mode : m;
    endfunction

    function automatic out_t pack_a();
        out_t o;
        o.hs = ia.h_sync; o.vs = ia.v_sync; o.de = ia.de;
        o.x = 8'(ia.x); o.y = 8'(ia.y);
        o.ls = ia.line_start; o.fs = ia.frame_start;
        o.rgb = {ia.R, ia.G, ia.B};
        return o;
    endfunction

    function automatic out_t pack_b();
        out_t o;
        o.hs = ib.h_sync; o.vs = ib.v_sync; o.de = ib.de;
        o.x = 8'(ib.x); o.y = 8'(ib.y);
        o.ls = ib.line_start; o.fs = ib.frame_start;
        o.rgb = {ib.R, ib.G, ib.B};
        return o;
    endfunction

    task automatic cmp_out(input string nm, input out_t act, input out_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got hs,vs,de,x,y,ls,fs,rgb=%b required %b", nm, $time, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d required %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: one expected record per pix_en edge, queued for the output check.
    out_t q_a[$], q_b[$];
    int a_h = 0, a_v = 0, b_h = 0, b_v = 0;
    logic [1:0] a_m = 2'd0, b_m = 2'd0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_h <= 0; a_v <= 0; a_m <= 2'd0;
            b_h <= 0; b_v <= 0; b_m <= 2'd0;
            q_a.delete();
            q_b.delete();
        end else if (pix_en) begin
            q_a.push_back(model(40, 4, 6, 20, 2, 3, 1'b0, 1'b0, a_h, a_v, nmode(a_h, a_v, a_m)));
            q_b.push_back(model(4, 1, 2, 3, 1, 1, 1'b1, 1'b1, b_h, b_v, nmode(b_h, b_v, b_m)));
            a_m <= nmode(a_h, a_v, a_m);
            b_m <= nmode(b_h, b_v, b_m);
            a_h <= (a_h == A_HT - 1) ? 0 : a_h + 1;
            a_v <= (a_h == A_HT - 1) ? ((a_v == A_VT - 1) ? 0 : a_v + 1) : a_v;
            b_h <= (b_h == B_HT - 1) ? 0 : b_h + 1;
            b_v <= (b_h == B_HT - 1) ? ((b_v == B_VT - 1) ? 0 : b_v + 1) : b_v;
        end
    end

    out_t exp_a, exp_b;
    task automatic sb_check();
        if (!rst) begin
            exp_a = rst_val(1'b0, 1'b0);
            exp_b = rst_val(1'b1, 1'b1);
        end else begin
            if (q_a.size() > 0) exp_a = q_a.pop_front();
            if (q_b.size() > 0) exp_b = q_b.pop_front();
        end
        cmp_out("sb_a", pack_a(), exp_a);
        cmp_out("sb_b", pack_b(), exp_b);
    endtask

    // Every clock, away from the active edge: outputs must equal the held expectation.
    always @(negedge clk) sb_check();

    function automatic logic sig(input int sel);
        case (sel)
            0:       return ia.frame_start;
            1:       return ia.line_start;
            2:       return ~ia.h_sync;
            3:       return ~ia.v_sync;
            4:       return ib.frame_start;
            5:       return ib.line_start;
            6:       return ib.h_sync;
            7:       return ib.v_sync;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_rise(input int sel, output bit ok);
        logic prev, cur;
        ok = 1'b0;
        prev = sig(sel);
        for (int i = 0; i < 8000 && !ok; i++) begin
            @(negedge clk);
            cur = sig(sel);
            if (cur && !prev) ok = 1'b1;
            prev = cur;
        end
    endtask

    // Period (clk cycles between rising edges) or width (clk cycles high) of a selected output.
    task automatic measure(input int sel, input bit width_mode, input int expv, input string nm);
        bit ok;
        int n;
        logic prev, cur;
        n = 0;
        wait_rise(sel, ok);
        prev = 1'b1;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 8000 && !ok; i++) begin
                @(negedge clk);
                n++;
                cur = sig(sel);
                if (width_mode ? !cur : (cur && !prev)) ok = 1'b1;
                prev = cur;
            end
        end
        check_int(nm, ok ? n : -1, expv);
    endtask

    task automatic wait_pix(input int px, input int py, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (ia.de && int'(ia.x) == px && int'(ia.y) == py) ok = 1'b1;
        end
    endtask

    task automatic check_first(input string nm);
        check_int({nm, "_fs_a"}, int'(ia.frame_start), 1);
        check_int({nm, "_ls_a"}, int'(ia.line_start), 1);
        check_int({nm, "_de_a"}, int'(ia.de), 1);
        check_int({nm, "_xy_a"}, int'({ia.x, ia.y}), 0);
        check_int({nm, "_fs_b"}, int'(ib.frame_start), 1);
    endtask

    vec_t vt [16];

    initial begin
        bit ok;
        int cur;
        vt[0]  = '{1, 0, 3, 3'b000};   vt[1]  = '{1, 5, 3, 3'b001};
        vt[2]  = '{1, 12, 3, 3'b010};  vt[3]  = '{1, 20, 3, 3'b100};
        vt[4]  = '{1, 39, 3, 3'b111};  vt[5]  = '{2, 15, 0, 3'b000};
        vt[6]  = '{2, 16, 0, 3'b111};  vt[7]  = '{2, 16, 16, 3'b000};
        vt[8]  = '{2, 3, 17, 3'b111};  vt[9]  = '{3, 5, 0, 3'b111};
        vt[10] = '{3, 0, 5, 3'b111};   vt[11] = '{3, 5, 5, 3'b000};
        vt[12] = '{3, 39, 7, 3'b111};  vt[13] = '{3, 38, 18, 3'b000};
        vt[14] = '{3, 5, 19, 3'b111};  vt[15] = '{0, 10, 10, 3'b000};

        rst = 1'b0;
        pat_mode = 2'd0;
        repeat (4) @(negedge clk);
        cmp_out("reset_a", pack_a(), rst_val(1'b0, 1'b0));
        cmp_out("reset_b", pack_b(), rst_val(1'b1, 1'b1));
        rst = 1'b1;
        @(negedge clk);
        check_first("first");

        measure(0, 1'b0, 1568, "a_frame_period");
        measure(1, 1'b0, 56,   "a_line_period");
        measure(2, 1'b1, 6,    "a_hsync_width");
        measure(3, 1'b1, 168,  "a_vsync_width");
        measure(4, 1'b0, 48,   "b_frame_period");
        measure(5, 1'b0, 8,    "b_line_period");
        measure(6, 1'b1, 2,    "b_hsync_width");
        measure(7, 1'b1, 8,    "b_vsync_width");

        // Mode change mid-frame: bars persist until the frame ends, then checker.
        pat_mode = 2'd1;
        wait_rise(0, ok);
        wait_rise(0, ok);
        wait_pix(0, 10, ok);
        pat_mode = 2'd2;
        wait_pix(20, 12, ok);
        check_int("bars_after_change", ok ? int'({ia.R, ia.G, ia.B}) : -1, 4);
        wait_pix(16, 0, ok);
        check_int("checker_next_frame", ok ? int'({ia.R, ia.G, ia.B}) : -1, 7);

        pe_alt = 1'b1;
        measure(0, 1'b0, 3136, "alt_a_frame_period");
        measure(0, 1'b1, 2,    "alt_a_fs_width");
        measure(1, 1'b0, 112,  "alt_a_line_period");
        measure(2, 1'b1, 12,   "alt_a_hsync_width");
        measure(4, 1'b0, 96,   "alt_b_frame_period");
        pe_alt = 1'b0;

        cur = -1;
        for (int i = 0; i < 16; i++) begin
            if (vt[i].mode != cur) begin
                pat_mode = 2'(vt[i].mode);
                cur = vt[i].mode;
                wait_rise(0, ok);
                wait_rise(0, ok);
            end
            wait_pix(vt[i].px, vt[i].py, ok);
            check_int($sformatf("vec%0d_m%0d_%0d_%0d", i, vt[i].mode, vt[i].px, vt[i].py),
                      ok ? int'({ia.R, ia.G, ia.B}) : -1, int'(vt[i].rgb));
        end

        // Asynchronous reset in the middle of a frame, then restart from (0,0).
        pat_mode = 2'd3;
        wait_pix(0, 15, ok);
        check_int("midframe_found", int'(ok), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        cmp_out("async_reset_a", pack_a(), rst_val(1'b0, 1'b0));
        cmp_out("async_reset_b", pack_b(), rst_val(1'b1, 1'b1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_first("restart");
        measure(0, 1'b0, 1568, "restart_frame_period");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
